// File: rtl/dlb_pkg.sv
// Shared types and helpers for dynamic_multi_line_buffer and its line RAMs.
package dlb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } dlb_state_e;

  // Line counter holds 0..NUM_LINES with NUM_LINES up to 8.
  localparam int unsigned LINE_CNT_W = 4;

  function automatic int unsigned dlb_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lb_line_ram.sv
// Simple dual-port line RAM: 1-cycle registered read, read-before-write on same address.
module lb_line_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/dynamic_multi_line_buffer.sv
// Runtime-width multi-line buffer with cascaded line RAMs and 1-cycle latency.
// Optional macro DLB_BORDER_REPLICATE_EN replicates the nearest filled line into unfilled lanes.
module dynamic_multi_line_buffer
  import dlb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_DEPTH  = 2048,
  parameter int unsigned NUM_LINES  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_sof,
  input  logic                            i_valid,
  input  logic [15:0]                     i_width,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_cur,
  output logic [NUM_LINES*DATA_WIDTH-1:0] o_taps,
  output logic                            o_lines_ready,
  output logic                            o_width_err
);

  localparam int unsigned AW = (dlb_clog2(MAX_DEPTH) < 1) ? 1 : dlb_clog2(MAX_DEPTH);
  localparam logic [15:0] MAX_W = 16'(MAX_DEPTH);
  localparam logic [LINE_CNT_W-1:0] NL = LINE_CNT_W'(NUM_LINES);

  dlb_state_e state_q, state_d, eff_state;
  logic [AW-1:0] col_q, col_d, eff_col, waddr_q, waddr_d;
  logic [LINE_CNT_W-1:0] line_q, line_d, eff_line, tap_line_q, tap_line_d;
  logic [15:0] width_q, width_d, eff_width;
  logic err_q, err_d, valid_q, valid_d, run_q, run_d, hit_q, hit_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d, fill;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] byp_q, byp_d, rd, raw, wdata, taps;
  logic sof, accept, legal, wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      line_q     <= '0;
      width_q    <= MAX_W;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      cur_q      <= '0;
      waddr_q    <= '0;
      tap_line_q <= '0;
      run_q      <= 1'b0;
      hit_q      <= 1'b0;
      byp_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      width_q    <= width_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      cur_q      <= cur_d;
      waddr_q    <= waddr_d;
      tap_line_q <= tap_line_d;
      run_q      <= run_d;
      hit_q      <= hit_d;
      byp_q      <= byp_d;
    end
  end

  // A qualified sof restarts the frame on the very pixel that carries it.
  always_comb begin
    sof       = i_sof & i_valid;
    accept    = i_valid & (sof | (state_q != IDLE));
    eff_state = sof ? FILL : state_q;
    eff_col   = sof ? '0 : col_q;
    eff_line  = sof ? '0 : line_q;
    legal     = (i_width != 16'd0) && (i_width <= MAX_W);
    eff_width = sof ? (legal ? i_width : MAX_W) : width_q;
    wrap      = (16'(eff_col) == eff_width - 16'd1);
    col_d     = col_q;
    line_d    = line_q;
    width_d   = width_q;
    err_d     = err_q;
    state_d   = state_q;
    if (sof) begin
      width_d = eff_width;
      err_d   = ~legal;
    end
    if (accept) begin
      col_d  = wrap ? '0 : eff_col + 1'b1;
      line_d = (wrap && eff_line < NL) ? eff_line + 1'b1 : eff_line;
    end
    unique case (state_q)
      IDLE:      if (sof) state_d = FILL;
      FILL, RUN: if (sof) state_d = FILL;
      default:   state_d = IDLE;
    endcase
    if (accept && state_d == FILL && line_d == NL) state_d = RUN;
  end

  // RAM writes trail the read by one cycle; a same-column hit (width 1) is
  // forwarded from the in-flight write so the cascade stays consistent.
  always_comb begin
    valid_d    = accept;
    cur_d      = accept ? i_data : cur_q;
    waddr_d    = accept ? eff_col : waddr_q;
    tap_line_d = accept ? eff_line : tap_line_q;
    run_d      = accept ? (eff_state == RUN) : run_q;
    hit_d      = accept & valid_q & (waddr_q == eff_col);
    raw        = '0;
    wdata      = '0;
    taps       = '0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      raw[k] = hit_q ? byp_q[k] : rd[k];
    end
    wdata[0] = cur_q;
    for (int unsigned k = 1; k < NUM_LINES; k++) begin
      wdata[k] = raw[k-1];
    end
    byp_d = hit_d ? wdata : byp_q;
`ifdef DLB_BORDER_REPLICATE_EN
    fill = cur_q;
    for (int unsigned j = 0; j < NUM_LINES; j++) begin
      if (tap_line_q == LINE_CNT_W'(j + 1)) fill = raw[j];
    end
`else
    fill = '0;
`endif
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      taps[k] = (LINE_CNT_W'(k) < tap_line_q) ? raw[k] : fill;
    end
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    lb_line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_DEPTH),
      .ADDR_WIDTH (AW)
    ) u_ram (
      .clk     (clk),
      .i_we    (valid_q),
      .i_waddr (waddr_q),
      .i_wdata (wdata[g]),
      .i_re    (accept),
      .i_raddr (eff_col),
      .o_rdata (rd[g])
    );
  end

  assign o_valid       = valid_q;
  assign o_cur         = cur_q;
  assign o_taps        = taps;
  assign o_lines_ready = run_q;
  assign o_width_err   = err_q;

endmodule

// File: tb/tb_dynamic_multi_line_buffer.sv
// Scoreboard bench for dynamic_multi_line_buffer (default build, NUM_LINES=2, 8-bit pixels).
module tb_dynamic_multi_line_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_width = 16'd0;
  logic [7:0]  i_data = 8'd0;
  logic        o_valid;
  logic [7:0]  o_cur;
  logic [15:0] o_taps;
  logic        o_lines_ready;
  logic        o_width_err;

  int total = 0;
  int bad = 0;

  dynamic_multi_line_buffer #(
    .DATA_WIDTH (8),
    .MAX_DEPTH  (2048),
    .NUM_LINES  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sof         (i_sof),
    .i_valid       (i_valid),
    .i_width       (i_width),
    .i_data        (i_data),
    .o_valid       (o_valid),
    .o_cur         (o_cur),
    .o_taps        (o_taps),
    .o_lines_ready (o_lines_ready),
    .o_width_err   (o_width_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cur;
    logic [15:0] taps;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t q[$];
  logic [7:0] pix [0:16383];
  int  m_idx = 0;
  int  m_w = 2048;
  bit  m_act = 1'b0;
  bit  m_err = 1'b0;

  // Reference model: pixel p of the frame sits at row p/w; the tap k+1 lines up is pixel p-(k+1)*w.
  always @(posedge clk) begin : model
    exp_t e;
    int   row;
    if (!rst_n) begin
      m_act = 1'b0;
      m_err = 1'b0;
      m_w   = 2048;
    end else if (i_valid && (i_sof || m_act)) begin
      if (i_sof) begin
        m_act = 1'b1;
        m_idx = 0;
        if (i_width == 16'd0 || i_width > 16'd2048) begin
          m_w   = 2048;
          m_err = 1'b1;
        end else begin
          m_w   = int'(i_width);
          m_err = 1'b0;
        end
      end
      row = m_idx / m_w;
      pix[m_idx % 16384] = i_data;
      e.cur = i_data;
      e.rdy = (row >= 2);
      e.err = m_err;
      e.taps = 16'h0000;
      for (int k = 0; k < 2; k++) begin
        if (row > k) e.taps[k*8 +: 8] = pix[(m_idx - (k + 1) * m_w) % 16384];
      end
      q.push_back(e);
      m_idx++;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    total++;
    assert (o_valid === (q.size() != 0)) else begin
      bad++;
      $error("FAIL valid_strobe: got %b want %b", o_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      assert (o_cur === e.cur) else begin
        bad++;
        $error("FAIL cur: got %0h want %0h", o_cur, e.cur);
      end
      total++;
      assert (o_taps === e.taps) else begin
        bad++;
        $error("FAIL taps: got %0h want %0h", o_taps, e.taps);
      end
      total++;
      assert (o_lines_ready === e.rdy) else begin
        bad++;
        $error("FAIL lines_ready: got %b want %b", o_lines_ready, e.rdy);
      end
      total++;
      assert (o_width_err === e.err) else begin
        bad++;
        $error("FAIL width_err: got %b want %b", o_width_err, e.err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic pix_in(input logic sof, input logic [7:0] d, input logic [15:0] w);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = d;
    i_width = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
    end
  endtask

  // Invalid cycle carrying junk, including an unqualified sof and an illegal width.
  task automatic gap();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b1;
    i_data  = 8'($urandom);
    i_width = 16'd0;
  endtask

  initial begin
    idle(3);
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_cur", 32'(o_cur), 32'd0);
    check("rst_taps", 32'(o_taps), 32'd0);
    check("rst_ready", 32'(o_lines_ready), 32'd0);
    check("rst_err", 32'(o_width_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three lines of width 4, pixels 1..12.
    pix_in(1'b1, 8'd1, 16'd4);
    for (int i = 2; i <= 12; i++) pix_in(1'b0, 8'(i), 16'd4);
    idle(1);
    @(negedge clk);
    check("w4_cur", 32'(o_cur), 32'd12);
    check("w4_taps", 32'(o_taps), 32'h0408);
    check("w4_ready", 32'(o_lines_ready), 32'd1);
    idle(2);

    // Same stream with a dead cycle between every valid pixel.
    pix_in(1'b1, 8'd1, 16'd4);
    for (int i = 2; i <= 12; i++) begin
      gap();
      pix_in(1'b0, 8'(i), 16'd4);
    end
    idle(1);
    @(negedge clk);
    check("tog_cur", 32'(o_cur), 32'd12);
    check("tog_taps", 32'(o_taps), 32'h0408);
    check("tog_ready", 32'(o_lines_ready), 32'd1);
    idle(2);

    // Width 0 falls back to 2048 and wraps there.
    pix_in(1'b1, 8'hC3, 16'd0);
    for (int i = 1; i < 2052; i++) pix_in(1'b0, 8'(i * 7), 16'd0);
    idle(1);
    @(negedge clk);
    check("w0_err", 32'(o_width_err), 32'd1);
    check("w0_ready", 32'(o_lines_ready), 32'd0);

    // Legal width clears the error; restart mid third line.
    pix_in(1'b1, 8'd100, 16'd8);
    for (int i = 1; i < 19; i++) pix_in(1'b0, 8'(100 + i), 16'd8);
    idle(1);
    @(negedge clk);
    check("w8_err", 32'(o_width_err), 32'd0);
    check("w8_ready", 32'(o_lines_ready), 32'd1);
    pix_in(1'b1, 8'hAA, 16'd8);
    idle(1);
    @(negedge clk);
    check("resof_ready", 32'(o_lines_ready), 32'd0);
    check("resof_taps", 32'(o_taps), 32'd0);
    for (int i = 1; i < 20; i++) pix_in(1'b0, 8'(200 + i), 16'd8);
    idle(2);

    // Width above the maximum is also illegal.
    pix_in(1'b1, 8'd5, 16'd3000);
    for (int i = 1; i < 6; i++) pix_in(1'b0, 8'(5 + i), 16'd0);
    idle(1);
    @(negedge clk);
    check("wbig_err", 32'(o_width_err), 32'd1);

    // Reset mid-frame, then pixels without sof must be ignored.
    pix_in(1'b1, 8'd50, 16'd4);
    for (int i = 1; i < 6; i++) pix_in(1'b0, 8'(50 + i), 16'd4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    i_data = 8'hEE;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) pix_in(1'b0, 8'(60 + i), 16'd4);
    idle(1);
    @(negedge clk);
    check("postrst_valid", 32'(o_valid), 32'd0);
    check("postrst_err", 32'(o_width_err), 32'd0);
    pix_in(1'b1, 8'd1, 16'd4);
    for (int i = 2; i <= 12; i++) pix_in(1'b0, 8'(i), 16'd4);
    idle(1);
    @(negedge clk);
    check("refill_taps", 32'(o_taps), 32'h0408);
    idle(3);
    @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
